// File: rtl/riscv_pkg.sv
// Shared types for the execute stage: ALU ops, forwarding selects, writeback
// selects and the ID/EX and EX/MEM pipeline register payloads.
package riscv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10,
        ALU_MUL   = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_write;
        logic              branch;
        logic              jump;
        logic              jalr;
        logic              alu_src;
        logic [3:0]        alu_ctrl;
        logic [2:0]        funct3;
        result_src_t       result_src;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
    } idex_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_write;
        result_src_t       result_src;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   write_data;
        logic [XLEN-1:0]   pc_plus4;
    } exmem_t;

endpackage

// File: rtl/execute_stage_alu.sv
// Single-cycle 32-bit ALU. Define EXEC_MUL_EN to add the low-word multiply
// on op 4'b1111; otherwise that code yields zero like any undefined op.
module alu
    import riscv_pkg::*;
(
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_XOR:   y = a ^ b;
            ALU_SLT:   y = XLEN'($signed(a) < $signed(b));
            ALU_SLTU:  y = XLEN'(a < b);
            ALU_SLL:   y = a << shamt;
            ALU_SRL:   y = a >> shamt;
            ALU_SRA:   y = $unsigned($signed(a) >>> shamt);
            ALU_PASSB: y = b;
`ifdef EXEC_MUL_EN
            ALU_MUL:   y = a * b;
`endif
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU, branch/jump
// resolution and EX/MEM register. Optional multiply via EXEC_MUL_EN (in alu).
module execute_stage
    import riscv_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              StallE_i,
    input  logic              FlushE_i,
    input  logic              ValidD_i,
    input  logic              RegWriteD_i,
    input  logic              MemWriteD_i,
    input  logic              BranchD_i,
    input  logic              JumpD_i,
    input  logic              JalrD_i,
    input  logic              ALUSrcD_i,
    input  logic [3:0]        ALUCtrlD_i,
    input  logic [2:0]        Funct3D_i,
    input  logic [1:0]        ResultSrcD_i,
    input  logic [XLEN-1:0]   RD1D_i,
    input  logic [XLEN-1:0]   RD2D_i,
    input  logic [XLEN-1:0]   ImmD_i,
    input  logic [XLEN-1:0]   PCD_i,
    input  logic [REG_AW-1:0] Rs1D_i,
    input  logic [REG_AW-1:0] Rs2D_i,
    input  logic [REG_AW-1:0] RdD_i,
    input  logic [1:0]        ForwardAE_i,
    input  logic [1:0]        ForwardBE_i,
    input  logic [XLEN-1:0]   ResultW_i,
    output logic [REG_AW-1:0] Rs1E_o,
    output logic [REG_AW-1:0] Rs2E_o,
    output logic [REG_AW-1:0] RdE_o,
    output logic              PCSrcE_o,
    output logic [XLEN-1:0]   PCTargetE_o,
    output logic              ValidM_o,
    output logic              RegWriteM_o,
    output logic              MemWriteM_o,
    output logic [1:0]        ResultSrcM_o,
    output logic [REG_AW-1:0] RdM_o,
    output logic [XLEN-1:0]   ALUResultM_o,
    output logic [XLEN-1:0]   WriteDataM_o,
    output logic [XLEN-1:0]   PCPlus4M_o
);

    idex_t           d_bus, e_q;
    exmem_t          m_next, m_q;
    logic [XLEN-1:0] src_a, fwd_b, src_b, alu_y, jalr_sum;
    logic            taken;

    always_comb begin
        d_bus            = '0;
        d_bus.valid      = ValidD_i;
        d_bus.reg_write  = RegWriteD_i;
        d_bus.mem_write  = MemWriteD_i;
        d_bus.branch     = BranchD_i;
        d_bus.jump       = JumpD_i;
        d_bus.jalr       = JalrD_i;
        d_bus.alu_src    = ALUSrcD_i;
        d_bus.alu_ctrl   = ALUCtrlD_i;
        d_bus.funct3     = Funct3D_i;
        d_bus.result_src = result_src_t'(ResultSrcD_i);
        d_bus.rd1        = RD1D_i;
        d_bus.rd2        = RD2D_i;
        d_bus.imm        = ImmD_i;
        d_bus.pc         = PCD_i;
        d_bus.rs1        = Rs1D_i;
        d_bus.rs2        = Rs2D_i;
        d_bus.rd         = RdD_i;
    end

    // ID/EX register; a flush wins over a stall and loads an all-zero bubble
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)          e_q <= '0;
        else if (FlushE_i)  e_q <= '0;
        else if (!StallE_i) e_q <= d_bus;
    end

    // Forwarding muxes; the unused select 2'b11 falls back to the register value
    always_comb begin
        src_a = e_q.rd1;
        fwd_b = e_q.rd2;
        case (fwd_sel_t'(ForwardAE_i))
            FWD_WB:  src_a = ResultW_i;
            FWD_MEM: src_a = m_q.alu_result;
            default: src_a = e_q.rd1;
        endcase
        case (fwd_sel_t'(ForwardBE_i))
            FWD_WB:  fwd_b = ResultW_i;
            FWD_MEM: fwd_b = m_q.alu_result;
            default: fwd_b = e_q.rd2;
        endcase
    end

    assign src_b = e_q.alu_src ? e_q.imm : fwd_b;

    alu u_alu (
        .op (e_q.alu_ctrl),
        .a  (src_a),
        .b  (src_b),
        .y  (alu_y)
    );

    // Branch condition compares the forwarded register operands, never the immediate
    always_comb begin
        taken = 1'b0;
        case (e_q.funct3)
            3'b000:  taken = (src_a == fwd_b);
            3'b001:  taken = (src_a != fwd_b);
            3'b100:  taken = ($signed(src_a) <  $signed(fwd_b));
            3'b101:  taken = ($signed(src_a) >= $signed(fwd_b));
            3'b110:  taken = (src_a <  fwd_b);
            3'b111:  taken = (src_a >= fwd_b);
            default: taken = 1'b0;
        endcase
    end

    assign jalr_sum    = src_a + e_q.imm;
    assign PCSrcE_o    = e_q.valid & (e_q.jump | (e_q.branch & taken));
    assign PCTargetE_o = e_q.jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (e_q.pc + e_q.imm);

    always_comb begin
        m_next            = '0;
        m_next.valid      = e_q.valid;
        m_next.reg_write  = e_q.reg_write & e_q.valid;
        m_next.mem_write  = e_q.mem_write & e_q.valid;
        m_next.result_src = e_q.result_src;
        m_next.rd         = e_q.rd;
        m_next.alu_result = alu_y;
        m_next.write_data = fwd_b;
        m_next.pc_plus4   = e_q.pc + XLEN'(4);
    end

    // EX/MEM register advances every cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) m_q <= '0;
        else       m_q <= m_next;
    end

    assign Rs1E_o       = e_q.rs1;
    assign Rs2E_o       = e_q.rs2;
    assign RdE_o        = e_q.rd;
    assign ValidM_o     = m_q.valid;
    assign RegWriteM_o  = m_q.reg_write;
    assign MemWriteM_o  = m_q.mem_write;
    assign ResultSrcM_o = m_q.result_src;
    assign RdM_o        = m_q.rd;
    assign ALUResultM_o = m_q.alu_result;
    assign WriteDataM_o = m_q.write_data;
    assign PCPlus4M_o   = m_q.pc_plus4;

endmodule

// File: tb/tb_execute_stage.sv
// Directed and randomized bench for execute_stage against a cycle-level
// reference model of the two pipeline registers.
module tb_execute_stage;
    import riscv_pkg::*;

    typedef struct {
        logic        valid, regw, memw, branch, jump, jalr, alusrc;
        logic [3:0]  ctrl;
        logic [2:0]  f3;
        logic [1:0]  rsrc;
        logic [31:0] rd1, rd2, imm, pc;
        logic [4:0]  rs1, rs2, rd;
    } instr_t;

    logic        clk, rst, stall, flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] result_w;
    instr_t      d_cur;

    logic [4:0]  Rs1E_o, Rs2E_o, RdE_o, RdM_o;
    logic        PCSrcE_o, ValidM_o, RegWriteM_o, MemWriteM_o;
    logic [1:0]  ResultSrcM_o;
    logic [31:0] PCTargetE_o, ALUResultM_o, WriteDataM_o, PCPlus4M_o;

    // reference model state
    instr_t      e_m;
    logic        m_valid, m_regw, m_memw;
    logic [1:0]  m_rsrc;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_wd, m_pc4;

    int checks = 0;
    int errors = 0;

    execute_stage dut (
        .clk_i(clk), .rst_i(rst), .StallE_i(stall), .FlushE_i(flush),
        .ValidD_i(d_cur.valid), .RegWriteD_i(d_cur.regw), .MemWriteD_i(d_cur.memw),
        .BranchD_i(d_cur.branch), .JumpD_i(d_cur.jump), .JalrD_i(d_cur.jalr),
        .ALUSrcD_i(d_cur.alusrc), .ALUCtrlD_i(d_cur.ctrl), .Funct3D_i(d_cur.f3),
        .ResultSrcD_i(d_cur.rsrc), .RD1D_i(d_cur.rd1), .RD2D_i(d_cur.rd2),
        .ImmD_i(d_cur.imm), .PCD_i(d_cur.pc), .Rs1D_i(d_cur.rs1), .Rs2D_i(d_cur.rs2),
        .RdD_i(d_cur.rd), .ForwardAE_i(fwd_a), .ForwardBE_i(fwd_b), .ResultW_i(result_w),
        .Rs1E_o(Rs1E_o), .Rs2E_o(Rs2E_o), .RdE_o(RdE_o), .PCSrcE_o(PCSrcE_o),
        .PCTargetE_o(PCTargetE_o), .ValidM_o(ValidM_o), .RegWriteM_o(RegWriteM_o),
        .MemWriteM_o(MemWriteM_o), .ResultSrcM_o(ResultSrcM_o), .RdM_o(RdM_o),
        .ALUResultM_o(ALUResultM_o), .WriteDataM_o(WriteDataM_o), .PCPlus4M_o(PCPlus4M_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t nop();
        instr_t x;
        x = '{valid:0, regw:0, memw:0, branch:0, jump:0, jalr:0, alusrc:0, ctrl:0, f3:0,
              rsrc:0, rd1:0, rd2:0, imm:0, pc:0, rs1:0, rs2:0, rd:0};
        return x;
    endfunction

    function automatic instr_t mk(logic [3:0] ctrl, logic [31:0] rd1, logic [31:0] rd2,
                                  logic [31:0] imm, logic [31:0] pc, logic [4:0] rd);
        instr_t x;
        x = nop();
        x.valid = 1; x.regw = 1; x.ctrl = ctrl;
        x.rd1 = rd1; x.rd2 = rd2; x.imm = imm; x.pc = pc;
        x.rs1 = 5'd1; x.rs2 = 5'd2; x.rd = rd;
        return x;
    endfunction

    // signed order via sign-bit flip, arithmetic shift via fill mask
    function automatic logic slt_ref(logic [31:0] a, logic [31:0] b);
        return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    endfunction

    function automatic logic [31:0] alu_ref(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int unsigned s;
        logic [31:0] ones;
        s = b % 32;
        ones = 32'hFFFF_FFFF;
        case (op)
            ALU_ADD:   return a + b;
            ALU_SUB:   return a + (~b) + 32'd1;
            ALU_AND:   return a & b;
            ALU_OR:    return a | b;
            ALU_XOR:   return a ^ b;
            ALU_SLT:   return slt_ref(a, b) ? 32'd1 : 32'd0;
            ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            ALU_SLL:   return a << s;
            ALU_SRL:   return a >> s;
            ALU_SRA:   return (a >> s) | (a[31] ? ~(ones >> s) : 32'd0);
            ALU_PASSB: return b;
`ifdef EXEC_MUL_EN
            ALU_MUL:   return a * b;
`endif
            default:   return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] fwd(logic [1:0] s, logic [31:0] r);
        if (s == 2'b01) return result_w;
        if (s == 2'b10) return m_alu;
        return r;
    endfunction

    function automatic logic exp_pcsrc();
        logic [31:0] a, b;
        logic t;
        a = fwd(fwd_a, e_m.rd1);
        b = fwd(fwd_b, e_m.rd2);
        case (e_m.f3)
            3'd0: t = (a == b);
            3'd1: t = (a != b);
            3'd4: t = slt_ref(a, b);
            3'd5: t = !slt_ref(a, b);
            3'd6: t = (a < b);
            3'd7: t = !(a < b);
            default: t = 1'b0;
        endcase
        return e_m.valid && (e_m.jump || (e_m.branch && t));
    endfunction

    function automatic logic [31:0] exp_target();
        if (e_m.jalr) return (fwd(fwd_a, e_m.rd1) + e_m.imm) & ~32'd1;
        return e_m.pc + e_m.imm;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_m = nop();
        m_valid = 0; m_regw = 0; m_memw = 0; m_rsrc = 0; m_rd = 0;
        m_alu = 0; m_wd = 0; m_pc4 = 0;
    endtask

    task automatic check_all();
        chk("ValidM", ValidM_o, m_valid);
        chk("RegWriteM", RegWriteM_o, m_regw);
        chk("MemWriteM", MemWriteM_o, m_memw);
        chk("RdM", RdM_o, m_rd);
        if (m_valid) begin
            chk("ResultSrcM", ResultSrcM_o, m_rsrc);
            chk("ALUResultM", ALUResultM_o, m_alu);
            chk("WriteDataM", WriteDataM_o, m_wd);
            chk("PCPlus4M", PCPlus4M_o, m_pc4);
        end
        chk("Rs1E", Rs1E_o, e_m.rs1);
        chk("Rs2E", Rs2E_o, e_m.rs2);
        chk("RdE", RdE_o, e_m.rd);
        chk("PCSrcE", PCSrcE_o, exp_pcsrc());
        if (e_m.valid) chk("PCTargetE", PCTargetE_o, exp_target());
    endtask

    task automatic check_reset_outputs();
        chk("rst_ValidM", ValidM_o, 0);
        chk("rst_RegWriteM", RegWriteM_o, 0);
        chk("rst_MemWriteM", MemWriteM_o, 0);
        chk("rst_ResultSrcM", ResultSrcM_o, 0);
        chk("rst_RdM", RdM_o, 0);
        chk("rst_ALUResultM", ALUResultM_o, 0);
        chk("rst_WriteDataM", WriteDataM_o, 0);
        chk("rst_PCPlus4M", PCPlus4M_o, 0);
        chk("rst_RdE", RdE_o, 0);
        chk("rst_Rs1E", Rs1E_o, 0);
        chk("rst_Rs2E", Rs2E_o, 0);
        chk("rst_PCSrcE", PCSrcE_o, 0);
    endtask

    // one clock: model both registers from pre-edge values, then compare
    task automatic tick();
        logic [31:0] a, b, sb;
        a  = fwd(fwd_a, e_m.rd1);
        b  = fwd(fwd_b, e_m.rd2);
        sb = e_m.alusrc ? e_m.imm : b;
        @(posedge clk);
        #1;
        m_valid = e_m.valid;
        m_regw  = e_m.valid & e_m.regw;
        m_memw  = e_m.valid & e_m.memw;
        m_rsrc  = e_m.rsrc;
        m_rd    = e_m.rd;
        m_alu   = alu_ref(e_m.ctrl, a, sb);
        m_wd    = b;
        m_pc4   = e_m.pc + 32'd4;
        if (flush)       e_m = nop();
        else if (!stall) e_m = d_cur;
        check_all();
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    instr_t x;

    initial begin
        rst = 1'b1; stall = 0; flush = 0; fwd_a = 0; fwd_b = 0; result_w = 0;
        d_cur = nop();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;

        // ADD 5+7 reaches M two clocks later
        d_cur = mk(4'(ALU_ADD), 32'd5, 32'd7, 32'd0, 32'h100, 5'd3);
        tick();
        d_cur = nop();
        tick();
        chk("add_result", ALUResultM_o, 32'd12);
        chk("add_regwrite", RegWriteM_o, 1);

        // forward MEM into A and WB into B for SUB
        d_cur = mk(4'(ALU_ADD), 32'h100, 32'd0, 32'd0, 32'h0, 5'd4);
        tick();
        d_cur = mk(4'(ALU_SUB), 32'hDEAD, 32'hBEEF, 32'd0, 32'h4, 5'd5);
        tick();
        fwd_a = 2'b10; fwd_b = 2'b01; result_w = 32'h20;
        d_cur = nop();
        tick();
        chk("fwd_sub", ALUResultM_o, 32'hE0);
        fwd_a = 0; fwd_b = 0; result_w = 0;

        // BEQ taken, then the same branch flushed
        x = mk(4'(ALU_SUB), 32'd3, 32'd3, 32'h10, 32'h40, 5'd0);
        x.regw = 0; x.branch = 1; x.f3 = 3'b000;
        d_cur = x;
        tick();
        chk("beq_pcsrc", PCSrcE_o, 1);
        chk("beq_target", PCTargetE_o, 32'h50);
        flush = 1;
        tick();
        chk("beq_flushed", PCSrcE_o, 0);
        flush = 0;

        // JALR clears bit 0 of the target; PC+4 in M
        x = mk(4'(ALU_ADD), 32'h1001, 32'd0, 32'd2, 32'h200, 5'd1);
        x.jump = 1; x.jalr = 1; x.rsrc = 2'(RES_PC4);
        d_cur = x;
        tick();
        chk("jalr_target", PCTargetE_o, 32'h1002);
        chk("jalr_pcsrc", PCSrcE_o, 1);
        d_cur = nop();
        tick();
        chk("jalr_pc4", PCPlus4M_o, 32'h204);

        // stall holds E for three cycles, then stall+flush makes a bubble
        d_cur = mk(4'(ALU_ADD), 32'd1, 32'd2, 32'd0, 32'h300, 5'd9);
        tick();
        stall = 1;
        d_cur = mk(4'(ALU_XOR), 32'h55, 32'hAA, 32'd0, 32'h304, 5'd10);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_rdE", RdE_o, 5'd9);
            chk("stall_aluM", ALUResultM_o, 32'd3);
        end
        flush = 1;
        tick();
        chk("stallflush_rdE", RdE_o, 5'd0);
        flush = 0; stall = 0;
        d_cur = nop();
        tick();
        chk("stallflush_validM", ValidM_o, 0);

        // reset mid-stream, then reset while stalled
        d_cur = mk(4'(ALU_OR), 32'hF0, 32'h0F, 32'd0, 32'h400, 5'd11);
        tick();
        tick();
        async_reset();
        d_cur = mk(4'(ALU_ADD), 32'd8, 32'd8, 32'd0, 32'h500, 5'd12);
        tick();
        stall = 1;
        tick();
        async_reset();
        tick();
        chk("rst_stall_validM", ValidM_o, 0);
        chk("rst_stall_rdE", RdE_o, 5'd0);
        stall = 0;

        // SRA sign fill
        d_cur = mk(4'(ALU_SRA), 32'h8000_0000, 32'd4, 32'd0, 32'h600, 5'd7);
        tick();
        d_cur = nop();
        tick();
        chk("sra", ALUResultM_o, 32'hF800_0000);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            x = mk(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, $urandom & 32'hFFFF_FFFC,
                   5'($urandom));
            if ($urandom_range(0, 3) == 0) x.rd2 = 32'($urandom_range(0, 40));
            if ($urandom_range(0, 3) == 0) x.rd1 = x.rd2;
            x.valid  = ($urandom_range(0, 7) != 0);
            x.regw   = 1'($urandom);
            x.memw   = 1'($urandom);
            x.branch = 1'($urandom);
            x.jump   = ($urandom_range(0, 5) == 0);
            x.jalr   = 1'($urandom);
            x.alusrc = 1'($urandom);
            x.f3     = 3'($urandom);
            x.rsrc   = 2'($urandom_range(0, 2));
            x.rs1    = 5'($urandom);
            x.rs2    = 5'($urandom);
            d_cur    = x;
            stall    = ($urandom_range(0, 7) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            result_w = $urandom;
            fwd_a    = 2'($urandom_range(0, m_valid ? 3 : 1));
            fwd_b    = 2'($urandom_range(0, m_valid ? 3 : 1));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 32 bits.
REQ-002 clk_i  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_i  in  1  asynchronous, active-high reset.
REQ-004 StallE_i  in  1  hold the ID/EX register.
REQ-005 FlushE_i  in  1  load a bubble into the ID/EX register.
REQ-006 ValidD_i, RegWriteD_i, MemWriteD_i, BranchD_i, JumpD_i, JalrD_i, ALUSrcD_i  in  1 each  decode control.
REQ-007 ALUCtrlD_i  in  4  ALU operation; Funct3D_i  in  3  branch condition; ResultSrcD_i  in  2  writeback select.
REQ-008 RD1D_i, RD2D_i, ImmD_i, PCD_i  in  32 each  decode operands.
REQ-009 Rs1D_i, Rs2D_i, RdD_i  in  5 each  register indices.
REQ-010 ForwardAE_i, ForwardBE_i  in  2 each  forwarding selects from the hazard unit.
REQ-011 ResultW_i  in  32  writeback result used for forwarding.
REQ-012 Rs1E_o, Rs2E_o, RdE_o  out  5 each  registered indices, to the hazard unit.
REQ-013 PCSrcE_o  out  1  redirect fetch; PCTargetE_o  out  32  redirect address.
REQ-014 ValidM_o, RegWriteM_o, MemWriteM_o  out  1 each; ResultSrcM_o  out  2; RdM_o  out  5; ALUResultM_o, WriteDataM_o, PCPlus4M_o  out  32 each.

Function
REQ-015 The ID/EX register SHALL capture all D inputs each cycle unless StallE_i is high or FlushE_i is high.
REQ-016 FlushE_i SHALL take priority over StallE_i; a flush SHALL clear Valid, RegWrite, MemWrite, Branch, Jump and Jalr and zero Rs1E/Rs2E/RdE; data fields are don't-care.
REQ-017 Operand A mux: 00 register RD1E, 01 ResultW_i, 10 ALUResultM_o, 11 SHALL behave as 00; operand B uses the same mapping over RD2E.
REQ-018 WriteDataM SHALL capture the forwarded operand B, before the immediate select.
REQ-019 SrcB SHALL be ImmE when ALUSrcE is 1, else the forwarded operand B.
REQ-020 ALU ops: ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, PASSB (LUI); shifts SHALL use SrcB[4:0]; adds SHALL wrap modulo 2^32; undefined codes SHALL yield 0.
REQ-021 Branch taken by Funct3E: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu; the others SHALL be not-taken.
REQ-022 PCSrcE_o = ValidE & (JumpE | (BranchE & taken)), combinational within the same cycle.
REQ-023 PCTargetE_o SHALL be PCE+ImmE, or (forwarded A + ImmE) & ~1 when JalrE is set.
REQ-024 The EX/MEM register SHALL advance every cycle with no stall; it SHALL gate RegWrite and MemWrite with ValidE.
REQ-025 PCPlus4M SHALL be PCE+4, wrapping modulo 2^32.
REQ-026 Latency: D inputs SHALL appear at M outputs two clocks later when there is no stall or flush.

Reset
REQ-027 rst_i SHALL immediately clear both registers: all M outputs 0, ValidE 0, and Rs1E_o, Rs2E_o and RdE_o 0.
REQ-028 Because of REQ-027, PCSrcE_o SHALL read 0 during reset.
REQ-029 Reset mid-stall SHALL discard the held instruction.

Configuration
REQ-030 EXEC_MUL_EN defined: ALUCtrl 4'b1111 SHALL compute the low 32 bits of the product of A and B in a single cycle.
REQ-031 EXEC_MUL_EN undefined: code 4'b1111 SHALL yield 0 and no multiplier SHALL be synthesized.

Structure
REQ-032 The shared package riscv_pkg SHALL hold the alu_op_t enum, the fwd_sel_t enum (REG, WB, MEM) and the result_src_t enum.
REQ-033 The ALU SHALL be a separate sub-module named alu, and it SHALL contain the EXEC_MUL_EN logic.

Verification
REQ-034 The bench SHALL cover all scenarios in REQ-035 to REQ-040.
REQ-035 ADD RD1=5, RD2=7, forwards 00 -> ALUResultM_o=12 two clocks later, with RegWriteM_o=1.
REQ-036 ForwardAE=10 with ALUResultM=0x100, ForwardBE=01 with ResultW=0x20, SUB -> next ALUResultM_o=0xE0.
REQ-037 BEQ with A=B=3, PC=0x40, Imm=0x10 -> PCSrcE_o=1 and PCTargetE_o=0x50; repeat with FlushE_i the cycle before -> PCSrcE_o=0.
REQ-038 JALR A=0x1001, Imm=2 -> PCTargetE_o=0x1002 and PCPlus4M_o=PC+4.
REQ-039 StallE_i held for 3 cycles -> E state unchanged; StallE_i and FlushE_i together -> bubble, ValidM_o=0 on the next cycle.
REQ-040 Assert rst_i asynchronously mid-stream -> all M outputs 0 before the next edge; SRA 0x80000000 by 4 -> 0xF8000000.
